// File: rtl/muxn_pkg.sv
// Shared definitions for the muxn_pipe block: the occupancy state encoding
// of the output skid buffer and a constant clog2 helper for sizing selects.
package muxn_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // Ceiling log2, usable in constant expressions (parameter sizing).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/muxn_sel.sv
// Combinational NUM_IN:1 channel selector. A select that names no channel
// yields zero data and raises the bad flag so the caller can count it.
module muxn_sel
    import muxn_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        data,
    output logic                    bad
);

    // Scan all channels; only an exact match drives data and clears bad.
    always_comb begin
        data = '0;
        bad  = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                data = in_data[i*WIDTH +: WIDTH];
                bad  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/muxn_pipe.sv
// N-input W-bit mux feeding a 2-entry skid buffer with valid/ready output.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready is a flop and never depends on out_ready in the same
// cycle; head data is held stable while out_valid is high and out_ready low.
// Optional feature macro: MUXN_PIPE_PARITY_EN adds out_parity, the XOR of
// the head entry's data, computed at accept and stored with each entry.
module muxn_pipe
    import muxn_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_IN    = 4,
    parameter int ERR_CNT_W = 8,
    localparam int SEL_W    = (clog2(NUM_IN) < 1) ? 1 : clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef MUXN_PIPE_PARITY_EN
    output logic                    out_parity,
`endif
    output logic                    sel_err,
    output logic [ERR_CNT_W-1:0]    err_cnt,
    output occ_e                    occ_state
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_bad;
    logic [WIDTH-1:0] tail_data;
    occ_e             occ;
    occ_e             next_occ;
    logic             accept;
    logic             pop;
`ifdef MUXN_PIPE_PARITY_EN
    logic             tail_par;
`endif

    muxn_sel #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_sel (
        .in_data (in_data),
        .sel     (in_sel),
        .data    (sel_data),
        .bad     (sel_bad)
    );

    // Flush overrides any offered input, so it also suppresses accept.
    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;
    assign out_valid = (occ != OCC_EMPTY);
    assign occ_state = occ;

    // Next occupancy from accept/pop; flush always empties the buffer.
    always_comb begin
        next_occ = occ;
        case (occ)
            OCC_EMPTY: if (accept) next_occ = OCC_ONE;
            OCC_ONE: begin
                if (accept && !pop)      next_occ = OCC_TWO;
                else if (!accept && pop) next_occ = OCC_EMPTY;
            end
            OCC_TWO:   if (pop) next_occ = OCC_ONE;
            default:   next_occ = OCC_EMPTY;
        endcase
        if (flush) next_occ = OCC_EMPTY;
    end

    // Occupancy FSM, head/tail entries, ready flop and error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ        <= OCC_EMPTY;
            in_ready   <= 1'b0;
            out_data   <= '0;
            tail_data  <= '0;
            sel_err    <= 1'b0;
            err_cnt    <= '0;
`ifdef MUXN_PIPE_PARITY_EN
            out_parity <= 1'b0;
            tail_par   <= 1'b0;
`endif
        end else begin
            occ      <= next_occ;
            in_ready <= (next_occ != OCC_TWO);
            sel_err  <= accept & sel_bad;
            if (accept && sel_bad && (err_cnt != {ERR_CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
            if (!flush) begin
                case (occ)
                    OCC_EMPTY: begin
                        if (accept) begin
                            out_data   <= sel_data;
`ifdef MUXN_PIPE_PARITY_EN
                            out_parity <= ^sel_data;
`endif
                        end
                    end
                    OCC_ONE: begin
                        if (accept && pop) begin
                            out_data   <= sel_data;
`ifdef MUXN_PIPE_PARITY_EN
                            out_parity <= ^sel_data;
`endif
                        end else if (accept) begin
                            tail_data  <= sel_data;
`ifdef MUXN_PIPE_PARITY_EN
                            tail_par   <= ^sel_data;
`endif
                        end
                    end
                    OCC_TWO: begin
                        if (pop) begin
                            out_data   <= tail_data;
`ifdef MUXN_PIPE_PARITY_EN
                            out_parity <= tail_par;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muxn_pipe.sv
// Testbench for muxn_pipe (NUM_IN=3 to exercise a non power-of-two channel
// count with one out-of-range select code). A queue-based reference model
// predicts every output each cycle; directed phases cover the named cases.
module tb_muxn_pipe;
    import muxn_pkg::*;

    localparam int WIDTH     = 32;
    localparam int NUM_IN    = 3;
    localparam int ERR_CNT_W = 8;
    localparam int SEL_W     = 2;

    logic                    clk;
    logic                    rst_n;
    logic                    flush;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;
    logic [ERR_CNT_W-1:0]    err_cnt;
    occ_e                    occ_state;
`ifdef MUXN_PIPE_PARITY_EN
    logic                    out_parity;
`endif

    muxn_pipe #(
        .WIDTH     (WIDTH),
        .NUM_IN    (NUM_IN),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef MUXN_PIPE_PARITY_EN
        .out_parity (out_parity),
`endif
        .sel_err    (sel_err),
        .err_cnt    (err_cnt),
        .occ_state  (occ_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard / reference model state
    logic [WIDTH-1:0]     exp_q[$];
    logic [WIDTH-1:0]     last_pop;
    logic                 last_ok;
    logic                 ready_m;
    logic                 sel_err_m;
    logic [ERR_CNT_W-1:0] cnt_m;
    int                   n_checks;
    int                   n_pass;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_pop  = '0;
        last_ok   = 1'b1;
        ready_m   = 1'b0;
        sel_err_m = 1'b0;
        cnt_m     = '0;
    endtask

    // Called at a negedge; leaves the bench at the negedge after release.
    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        model_reset();
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_sel_err", 64'(sel_err), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_low", 64'(in_ready), 64'd0);
    endtask

    // One clock: drive at the negedge, compare against the model, step the
    // model across the rising edge, return at the following negedge.
    task automatic cycle(input logic v, input logic [SEL_W-1:0] s,
                         input logic [NUM_IN*WIDTH-1:0] d, input logic ordy, input logic fl);
        logic             acc;
        logic             pp;
        logic             bad;
        logic [WIDTH-1:0] ch;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        check("in_ready", 64'(in_ready), 64'(ready_m));
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("out_data", 64'(out_data), 64'(exp_q[0]));
`ifdef MUXN_PIPE_PARITY_EN
            check("out_parity", 64'(out_parity), 64'(^exp_q[0]));
`endif
        end else if (last_ok) begin
            check("idle_data", 64'(out_data), 64'(last_pop));
        end
        check("sel_err", 64'(sel_err), 64'(sel_err_m));
        check("err_cnt", 64'(err_cnt), 64'(cnt_m));
        acc = v && ready_m;
        pp  = (exp_q.size() != 0) && ordy;
        bad = (int'(s) >= NUM_IN);
        ch  = '0;
        if (!bad) ch = d[int'(s)*WIDTH +: WIDTH];
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
            last_ok   = 1'b0;
            sel_err_m = 1'b0;
        end else begin
            if (pp) begin
                last_pop = exp_q.pop_front();
                last_ok  = 1'b1;
            end
            sel_err_m = acc && bad;
            if (acc) begin
                exp_q.push_back(ch);
                if (bad && cnt_m != {ERR_CNT_W{1'b1}}) cnt_m = cnt_m + 1'b1;
            end
        end
        ready_m = (exp_q.size() < 2);
        @(negedge clk);
    endtask

    function automatic logic [NUM_IN*WIDTH-1:0] rnd_bus();
        logic [NUM_IN*WIDTH-1:0] b;
        for (int i = 0; i < NUM_IN; i++) b[i*WIDTH +: WIDTH] = $urandom;
        return b;
    endfunction

    initial begin
        logic [NUM_IN*WIDTH-1:0] bus;
        logic [ERR_CNT_W-1:0]    cnt_before;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b1;
        @(negedge clk);
        apply_reset();
        cycle(1'b0, 2'd0, '0, 1'b1, 1'b0);
        check("first_edge_ready", 64'(in_ready), 64'd1);

        // Single transfer through channel 2
        bus = rnd_bus();
        bus[2*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
        cycle(1'b1, 2'd2, bus, 1'b1, 1'b0);
        check("t2_valid", 64'(out_valid), 64'd1);
        check("t2_data", 64'(out_data), 64'hDEAD_BEEF);
        cycle(1'b0, 2'd0, '0, 1'b1, 1'b0);

        // Back-pressure: two entries fill the buffer, then drain in order
        cycle(1'b1, 2'd0, rnd_bus(), 1'b0, 1'b0);
        cycle(1'b1, 2'd1, rnd_bus(), 1'b0, 1'b0);
        check("t3_full_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 2'd2, rnd_bus(), 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 2'd0, '0, 1'b1, 1'b0);

        // Reset in the middle of a transfer discards everything
        cycle(1'b1, 2'd1, rnd_bus(), 1'b0, 1'b0);
        cycle(1'b1, 2'd3, rnd_bus(), 1'b0, 1'b0);
        apply_reset();
        cycle(1'b0, 2'd0, '0, 1'b1, 1'b0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);

        // Out-of-range select: zero data, one-cycle pulse, count 1
        cycle(1'b1, 2'd3, rnd_bus(), 1'b1, 1'b0);
        check("t4_pulse", 64'(sel_err), 64'd1);
        check("t4_zero_data", 64'(out_data), 64'd0);
        cycle(1'b0, 2'd0, '0, 1'b1, 1'b0);
        check("t4_pulse_end", 64'(sel_err), 64'd0);
        check("t4_cnt", 64'(err_cnt), 64'd1);

        // Flush from TWO with a bad-select input offered at the same edge
        cycle(1'b1, 2'd0, rnd_bus(), 1'b0, 1'b0);
        cycle(1'b1, 2'd1, rnd_bus(), 1'b0, 1'b0);
        cnt_before = cnt_m;
        cycle(1'b1, 2'd3, rnd_bus(), 1'b0, 1'b1);
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_ready", 64'(in_ready), 64'd1);
        check("t5_cnt", 64'(err_cnt), 64'(cnt_before));
        cycle(1'b1, 2'd3, rnd_bus(), 1'b1, 1'b1);
        cycle(1'b0, 2'd0, '0, 1'b1, 1'b0);

`ifdef MUXN_PIPE_PARITY_EN
        bus = '0;
        bus[WIDTH-1:0] = 32'h0000_0007;
        cycle(1'b1, 2'd0, bus, 1'b1, 1'b0);
        check("t6_par7", 64'(out_parity), 64'd1);
        bus[WIDTH-1:0] = 32'h0000_0003;
        cycle(1'b1, 2'd0, bus, 1'b1, 1'b0);
        check("t6_par3", 64'(out_parity), 64'd0);
        cycle(1'b0, 2'd0, '0, 1'b1, 1'b0);
`endif

        // Saturation of the error counter
        repeat (300) cycle(1'b1, 2'd3, rnd_bus(), 1'b1, 1'b0);
        cycle(1'b0, 2'd0, '0, 1'b1, 1'b0);
        check("t4_sat", 64'(err_cnt), 64'd255);

        // Randomized traffic against the model
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 3) != 0, SEL_W'($urandom_range(0, 3)), rnd_bus(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
